// File: rtl/serial_add_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : serial_add_ctrl (with helper module half_adder)
//  Description : Bit-serial adder sequencer. Accepts a WIDTH-bit operand pair
//                over a valid/ready handshake. Adds one bit per clock, LSB
//                first, through a single full-adder slice made of two half
//                adders and an OR. Returns sum/carry_out over a second
//                valid/ready handshake.
//  Options     : define SERIAL_ADD_CTRL_OVF_EN to add the signed-overflow
//                output 'ovf' and its flop.
//  Revision    : 1.0 - initial release
// ============================================================================

// Single half-adder cell; two of these plus an OR form the full-adder slice.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
`ifdef SERIAL_ADD_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must be able to hold WIDTH-1; sized so WIDTH=1 still gets one bit.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder slice: propagate/generate from the operand LSBs, then fold in
  // the carry flop with a second half adder.
  logic ha0_s, ha0_c;
  logic slice_s, ha1_c;
  logic slice_c;

  half_adder u_ha0 (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (slice_s),
    .c_o (ha1_c)
  );

  assign slice_c = ha0_c | ha1_c;

  // Handshake and status flags decode straight from state.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign sum       = sum_q;
  assign carry_out = carry_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Next-state and datapath update: load on accept, one bit per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = slice_s;
        carry_d          = slice_c;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
`ifdef SERIAL_ADD_CTRL_OVF_EN
          // Carry into the MSB is the carry flop on this last cycle.
          ovf_d   = carry_q ^ slice_c;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADD_CTRL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Directed self-checking bench for serial_add_ctrl, using a
//                WIDTH=8 instance and a WIDTH=2 instance for a full sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=8 instance signals
  logic       iv, ir, ov, orr, bz, co;
  logic [7:0] av, bv, sm;
  // WIDTH=2 instance signals
  logic       iv2, ir2, ov2, or2, bz2, co2;
  logic [1:0] a2, b2, sm2;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic       of8, of2;
`endif

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv),
    .in_ready  (ir),
    .a         (av),
    .b         (bv),
    .out_valid (ov),
    .out_ready (orr),
    .sum       (sm),
    .carry_out (co),
    .busy      (bz)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    .ovf       (of8)
`endif
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .a         (a2),
    .b         (b2),
    .out_valid (ov2),
    .out_ready (or2),
    .sum       (sm2),
    .carry_out (co2),
    .busy      (bz2)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    .ovf       (of2)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         lat;
  logic [7:0] rs;
  logic       rc, ro;

  // Stimulus only: offer one operand pair to the WIDTH=8 instance (assumed
  // idle) and wait, bounded, for out_valid. Returns the edges from accept.
  task automatic run_add8(input logic [7:0] x, input logic [7:0] y,
                          output int l, output logic [7:0] s,
                          output logic c, output logic o);
    av = x; bv = y; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0; av = 8'hxx; bv = 8'hxx;
    l = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ov) begin
        l = k;
        break;
      end
    end
    s = sm; c = co;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    o = of8;
`else
    o = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = 1'b0; iv2 = 1'b0; orr = 1'b1; or2 = 1'b1;
    av = '0; bv = '0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (ir !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", ir); end
    checks++; if (ov !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got %b want 0", ov); end
    checks++; if (bz !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", bz); end
    checks++; if (sm !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sm); end
    checks++; if (co !== 1'b0)  begin errors++; $display("FAIL reset_carry got %b want 0", co); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL reset_w2_in_ready got %b want 1", ir2); end
`ifdef SERIAL_ADD_CTRL_OVF_EN
    checks++; if (of8 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", of8); end
`endif
  endtask

  task automatic test_basic();
    bit busy_seen;
    av = 8'h35; bv = 8'h4A; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    busy_seen = bz;
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bz); end
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL basic_in_ready_run got %b want 0", ir); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ov) begin lat = k; break; end
    end
    checks++; if (lat != 8)     begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (sm !== 8'h7F) begin errors++; $display("FAIL basic_sum got %h want 7f", sm); end
    checks++; if (co !== 1'b0)  begin errors++; $display("FAIL basic_carry got %b want 0", co); end
`ifdef SERIAL_ADD_CTRL_OVF_EN
    checks++; if (of8 !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", of8); end
`endif
    @(posedge clk); #1;
    checks++; if (ir !== 1'b1 || ov !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle got in_ready=%b out_valid=%b want 1/0", ir, ov);
    end
  endtask

  task automatic test_wrap();
    run_add8(8'hFF, 8'h01, lat, rs, rc, ro);
    checks++; if (rs !== 8'h00) begin errors++; $display("FAIL wrap_ff01_sum got %h want 00", rs); end
    checks++; if (rc !== 1'b1)  begin errors++; $display("FAIL wrap_ff01_carry got %b want 1", rc); end
`ifdef SERIAL_ADD_CTRL_OVF_EN
    checks++; if (ro !== 1'b0)  begin errors++; $display("FAIL wrap_ff01_ovf got %b want 0", ro); end
`endif
    @(posedge clk); #1;
    run_add8(8'h7F, 8'h01, lat, rs, rc, ro);
    checks++; if (rs !== 8'h80) begin errors++; $display("FAIL wrap_7f01_sum got %h want 80", rs); end
    checks++; if (rc !== 1'b0)  begin errors++; $display("FAIL wrap_7f01_carry got %b want 0", rc); end
`ifdef SERIAL_ADD_CTRL_OVF_EN
    checks++; if (ro !== 1'b1)  begin errors++; $display("FAIL wrap_7f01_ovf got %b want 1", ro); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    orr = 1'b0;
    run_add8(8'h12, 8'h34, lat, rs, rc, ro);
    checks++; if (rs !== 8'h46) begin errors++; $display("FAIL bp_sum got %h want 46", rs); end
    for (int i = 0; i < 5; i++) begin
      av = 8'hFF; bv = 8'hFF; iv = 1'b1;
      @(posedge clk); #1;
      checks++; if (ov !== 1'b1 || ir !== 1'b0 || sm !== 8'h46 || co !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got out_valid=%b in_ready=%b sum=%h carry=%b want 1/0/46/0",
                 i, ov, ir, sm, co);
      end
    end
    iv = 1'b0; orr = 1'b1;
    @(posedge clk); #1;
    checks++; if (ir !== 1'b1 || ov !== 1'b0 || sm !== 8'h46) begin
      errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b sum=%h want 1/0/46", ir, ov, sm);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    av = 8'hAA; bv = 8'h55; iv = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", bz); end
    rst = 1'b1;
    #1;
    checks++; if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0 || sm !== 8'h00) begin
      errors++; $display("FAIL rmid_async got in_ready=%b out_valid=%b busy=%b sum=%h want 1/0/0/00",
                         ir, ov, bz, sm);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_no_result got seen=%b want 0", seen); end
    run_add8(8'h01, 8'h02, lat, rs, rc, ro);
    checks++; if (rs !== 8'h03 || rc !== 1'b0 || lat != 8) begin
      errors++; $display("FAIL rmid_next_add got sum=%h carry=%b lat=%0d want 03/0/8", rs, rc, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_w2();
    int         acc, last_acc, k;
    logic [3:0] pv;
    logic [2:0] exp_r;
    last_acc = 0;
    for (int p = 0; p < 16; p++) begin
      k = 0;
      while (!ir2 && k < 10) begin @(posedge clk); #1; k++; end
      checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL w2_idle_timeout pair=%0d got %b want 1", p, ir2); end
      pv = p[3:0];
      a2 = pv[3:2]; b2 = pv[1:0]; iv2 = 1'b1;
      exp_r = {1'b0, pv[3:2]} + {1'b0, pv[1:0]};
      @(posedge clk); #1;
      iv2 = 1'b0;
      acc = cyc;
      if (p > 0) begin
        checks++; if (acc - last_acc != 4) begin
          errors++; $display("FAIL w2_interval pair=%0d got %0d want 4", p, acc - last_acc);
        end
      end
      last_acc = acc;
      k = 0;
      while (!ov2 && k < 10) begin @(posedge clk); #1; k++; end
      checks++; if (ov2 !== 1'b1 || {co2, sm2} !== exp_r) begin
        errors++; $display("FAIL w2_sum pair a=%0d b=%0d got valid=%b {c,s}=%b want 1/%b",
                           pv[3:2], pv[1:0], ov2, {co2, sm2}, exp_r);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back_w2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
